// File: rtl/ps2_key_sequencer.sv
// PS/2 scan-code sequencer: decodes make/break/extended prefixes, suppresses typematic
// repeats with a per-letter held mask, and queues new letter presses in a small FIFO.
module ps2_key_sequencer #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned PTR_W = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        code_valid,
    input  logic [7:0]  code,
    input  logic        event_ready,
    output logic        event_valid,
    output logic [4:0]  event_letter,
    output logic [17:0] held,
    output logic        overflow,
    input  logic        clear_ovf
);

    localparam int unsigned LETTER_W = 5;
    localparam int unsigned NUM_KEYS = 18;
    localparam int unsigned CNT_W    = PTR_W + 1;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_BREAK   = 2'd1;
    localparam logic [1:0] ST_EXT     = 2'd2;
    localparam logic [1:0] ST_EXT_BRK = 2'd3;

    localparam logic [7:0] CODE_BREAK = 8'hF0;
    localparam logic [7:0] CODE_EXT   = 8'hE0;
    localparam logic [7:0] CODE_BAT   = 8'hAA;

    // Make code to letter index; 0 means unmapped.
    function automatic logic [LETTER_W-1:0] letter_of(input logic [7:0] c);
        logic [LETTER_W-1:0] l;
        case (c)
            8'h1C:   l = 5'd1;
            8'h32:   l = 5'd2;
            8'h21:   l = 5'd3;
            8'h23:   l = 5'd4;
            8'h24:   l = 5'd5;
            8'h2B:   l = 5'd6;
            8'h34:   l = 5'd7;
            8'h33:   l = 5'd8;
            8'h3B:   l = 5'd9;
            8'h4B:   l = 5'd10;
            8'h31:   l = 5'd11;
            8'h44:   l = 5'd12;
            8'h4D:   l = 5'd13;
            8'h15:   l = 5'd14;
            8'h2D:   l = 5'd15;
            8'h1B:   l = 5'd16;
            8'h3C:   l = 5'd17;
            8'h35:   l = 5'd18;
            default: l = 5'd0;
        endcase
        return l;
    endfunction

    logic [1:0]          state_q, state_d;
    logic [NUM_KEYS-1:0] held_q, held_d;
    logic                ovf_q, ovf_d;
    logic [PTR_W-1:0]    wr_q, wr_d;
    logic [PTR_W-1:0]    rd_q, rd_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [LETTER_W-1:0] mem_q [DEPTH];
    logic [LETTER_W-1:0] mem_d [DEPTH];
    logic                valid_q, valid_d;
    logic [LETTER_W-1:0] letter_q, letter_d;

    logic [LETTER_W-1:0] code_letter;
    logic                code_mapped;
    logic [NUM_KEYS-1:0] key_mask;
    logic                make;
    logic                push_req;
    logic                push;
    logic                pop;
    logic                full;
    logic                drop;

    assign code_letter = letter_of(code);
    assign code_mapped = (code_letter != 5'd0);
    assign key_mask    = code_mapped ? (NUM_KEYS'(1) << (code_letter - 5'd1)) : '0;

    // Prefix FSM and held-mask tracking.
    always_comb begin
        state_d = state_q;
        held_d  = held_q;
        make    = 1'b0;
        if (code_valid) begin
            case (state_q)
                ST_IDLE: begin
                    if (code == CODE_BREAK) begin
                        state_d = ST_BREAK;
                    end else if (code == CODE_EXT) begin
                        state_d = ST_EXT;
                    end else if (code == CODE_BAT) begin
                        held_d = '0;
                    end else if (code_mapped) begin
                        make = 1'b1;
                    end
                end
                ST_BREAK: begin
                    state_d = ST_IDLE;
                    if (code_mapped) begin
                        held_d = held_q & ~key_mask;
                    end
                end
                ST_EXT: begin
                    state_d = (code == CODE_BREAK) ? ST_EXT_BRK : ST_IDLE;
                end
                ST_EXT_BRK: begin
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
        push_req = make && ((held_q & key_mask) == '0);
        if (push_req) begin
            held_d = held_q | key_mask;
        end
    end

    // FIFO next state; a push on a full FIFO survives only alongside a pop.
    always_comb begin
        mem_d = mem_q;
        pop   = valid_q && event_ready;
        full  = (cnt_q == CNT_W'(DEPTH));
        push  = push_req && (!full || pop);
        drop  = push_req && full && !pop;
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        if (push) begin
            mem_d[wr_q] = code_letter;
            wr_d        = wr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_d = rd_q + PTR_W'(1);
        end
        if (push && !pop) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else if (pop && !push) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
        ovf_d    = (ovf_q && !clear_ovf) || drop;
        valid_d  = (cnt_d != '0);
        letter_d = valid_d ? mem_d[rd_d] : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            held_q   <= '0;
            ovf_q    <= 1'b0;
            wr_q     <= '0;
            rd_q     <= '0;
            cnt_q    <= '0;
            valid_q  <= 1'b0;
            letter_q <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            held_q   <= held_d;
            ovf_q    <= ovf_d;
            wr_q     <= wr_d;
            rd_q     <= rd_d;
            cnt_q    <= cnt_d;
            valid_q  <= valid_d;
            letter_q <= letter_d;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

    assign event_valid  = valid_q;
    assign event_letter = letter_q;
    assign held         = held_q;
    assign overflow     = ovf_q;

endmodule

// File: tb/tb_ps2_key_sequencer.sv
// Directed bench for ps2_key_sequencer: inputs driven on negedge, outputs checked on negedge.
module tb_ps2_key_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        code_valid;
    logic [7:0]  code;
    logic        event_ready;
    logic        event_valid;
    logic [4:0]  event_letter;
    logic [17:0] held;
    logic        overflow;
    logic        clear_ovf;

    int total = 0;
    int bad   = 0;

    ps2_key_sequencer #(.DEPTH(4), .PTR_W(2)) dut (
        .clk          (clk),
        .rst          (rst),
        .code_valid   (code_valid),
        .code         (code),
        .event_ready  (event_ready),
        .event_valid  (event_valid),
        .event_letter (event_letter),
        .held         (held),
        .overflow     (overflow),
        .clear_ovf    (clear_ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] c);
        @(negedge clk);
        code_valid = 1'b1;
        code       = c;
        @(negedge clk);
        code_valid = 1'b0;
        code       = 8'h00;
    endtask

    task automatic pop_one();
        event_ready = 1'b1;
        @(negedge clk);
        event_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b1; code_valid = 1'b0; code = 8'h00; event_ready = 1'b0; clear_ovf = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("rst_valid", 32'(event_valid), 32'd0);
        chk("rst_letter", 32'(event_letter), 32'd0);
        chk("rst_held", 32'(held), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);

        // ready on an empty FIFO must not move pointers
        event_ready = 1'b1;
        repeat (2) @(negedge clk);
        event_ready = 1'b0;
        chk("empty_ready_valid", 32'(event_valid), 32'd0);

        // 1) single make, then pop
        send(8'h1C);
        chk("t1_valid", 32'(event_valid), 32'd1);
        chk("t1_letter", 32'(event_letter), 32'd1);
        chk("t1_held", 32'(held), 32'h1);
        pop_one();
        chk("t1_pop_valid", 32'(event_valid), 32'd0);
        chk("t1_pop_letter", 32'(event_letter), 32'd0);
        send(8'hF0);
        send(8'h1C);
        chk("t1_release", 32'(held), 32'h0);

        // 2) typematic repeats give one event
        send(8'h1C);
        send(8'h1C);
        send(8'h1C);
        chk("t2_valid", 32'(event_valid), 32'd1);
        chk("t2_letter", 32'(event_letter), 32'd1);
        chk("t2_held", 32'(held), 32'h1);
        pop_one();
        chk("t2_one_event", 32'(event_valid), 32'd0);
        send(8'hF0);
        send(8'h1C);
        chk("t2_release", 32'(held), 32'h0);
        chk("t2_no_event", 32'(event_valid), 32'd0);

        // 3) break consumes the byte, next byte is a fresh make
        send(8'hF0);
        send(8'h1C);
        chk("t3_break_no_event", 32'(event_valid), 32'd0);
        send(8'h1C);
        chk("t3_valid", 32'(event_valid), 32'd1);
        chk("t3_letter", 32'(event_letter), 32'd1);
        pop_one();
        send(8'hAA);
        chk("t3_bat_clear", 32'(held), 32'h0);

        // 4) fill, overflow on fifth, ordered drain, clear overflow
        send(8'h1C);
        send(8'h32);
        send(8'h21);
        send(8'h23);
        chk("t4_ovf_before", 32'(overflow), 32'd0);
        chk("t4_head_hold", 32'(event_letter), 32'd1);
        send(8'h24);
        chk("t4_ovf", 32'(overflow), 32'd1);
        chk("t4_held", 32'(held), 32'h1F);
        for (int i = 1; i <= 4; i++) begin
            chk("t4_pop_valid", 32'(event_valid), 32'd1);
            chk("t4_pop_letter", 32'(event_letter), 32'(i));
            pop_one();
        end
        chk("t4_empty", 32'(event_valid), 32'd0);
        chk("t4_ovf_sticky", 32'(overflow), 32'd1);
        @(negedge clk);
        clear_ovf = 1'b1;
        @(negedge clk);
        clear_ovf = 1'b0;
        chk("t4_ovf_clear", 32'(overflow), 32'd0);

        // 5) full FIFO: push and pop in the same cycle
        send(8'hAA);
        send(8'h1C);
        send(8'h32);
        send(8'h21);
        send(8'h23);
        @(negedge clk);
        event_ready = 1'b1;
        code_valid  = 1'b1;
        code        = 8'h35;
        @(negedge clk);
        code_valid = 1'b0;
        code       = 8'h00;
        chk("t5_ovf", 32'(overflow), 32'd0);
        chk("t5_letter_a", 32'(event_letter), 32'd2);
        @(negedge clk);
        chk("t5_letter_b", 32'(event_letter), 32'd3);
        @(negedge clk);
        chk("t5_letter_c", 32'(event_letter), 32'd4);
        @(negedge clk);
        chk("t5_last", 32'(event_letter), 32'd18);
        chk("t5_last_valid", 32'(event_valid), 32'd1);
        @(negedge clk);
        chk("t5_empty", 32'(event_valid), 32'd0);
        event_ready = 1'b0;

        // 6) extended codes ignored; reset mid-break
        send(8'hAA);
        send(8'hE0);
        send(8'h1C);
        chk("t6_ext_no_event", 32'(event_valid), 32'd0);
        chk("t6_ext_held", 32'(held), 32'h0);
        send(8'hE0);
        send(8'hF0);
        send(8'h1C);
        chk("t6_extbrk_held", 32'(held), 32'h0);
        send(8'h1C);
        chk("t6_after_ext_letter", 32'(event_letter), 32'd1);
        send(8'hF0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("t6_rst_valid", 32'(event_valid), 32'd0);
        chk("t6_rst_held", 32'(held), 32'h0);
        send(8'h1C);
        chk("t6_after_rst_valid", 32'(event_valid), 32'd1);
        chk("t6_after_rst_letter", 32'(event_letter), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
